// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store,
// sequencing each access through a fixed-latency IDLE -> WAIT -> RESP handshake.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int LW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LATENCY);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [1:0]    state_r;
   logic [LW-1:0] lat_cnt_r;
   logic [SW-1:0] starve_cnt_r;
   logic          owner_dm_r;
   logic          cancel_r;
   logic          fetch_pend_s;
   logic          grant_dm_s;
   logic          grant_if_s;
   logic          cancel_now_s;

   assign stall_if  = if_req & ~if_ack & ~if_cancel;
   assign stall_mem = dm_req & ~dm_ack;
   assign busy      = (state_r != IDLE);

   // Grant decision in IDLE: data first unless the fetch has been starved too long.
   always_comb begin
      fetch_pend_s = if_req & ~if_cancel;
      grant_dm_s   = 1'b0;
      grant_if_s   = 1'b0;
      cancel_now_s = cancel_r | (~owner_dm_r & if_cancel);
      if (state_r == IDLE) begin
         if (dm_req && !(fetch_pend_s && (starve_cnt_r == STARVE_LIM))) begin
            grant_dm_s = 1'b1;
         end else if (fetch_pend_s) begin
            grant_if_s = 1'b1;
         end else begin
            grant_dm_s = 1'b0;
            grant_if_s = 1'b0;
         end
      end else begin
         grant_dm_s = 1'b0;
         grant_if_s = 1'b0;
      end
   end

   // Access sequencer, memory port registers and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         lat_cnt_r    <= '0;
         starve_cnt_r <= '0;
         owner_dm_r   <= 1'b0;
         cancel_r     <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         if_rdata     <= '0;
         dm_rdata     <= '0;
         if_ack       <= 1'b0;
         dm_ack       <= 1'b0;
      end else begin
         mem_en <= 1'b0;
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_dm_s) begin
                  state_r    <= WAIT;
                  mem_en     <= 1'b1;
                  mem_we     <= dm_we;
                  mem_addr   <= dm_addr;
                  lat_cnt_r  <= LAT_LOAD;
                  owner_dm_r <= 1'b1;
                  if (dm_we) begin
                     mem_wdata <= dm_wdata;
                  end
                  // Count data grants that overtook a waiting fetch.
                  if (fetch_pend_s) begin
                     if (starve_cnt_r != STARVE_LIM) begin
                        starve_cnt_r <= starve_cnt_r + SW'(1);
                     end
                  end else begin
                     starve_cnt_r <= '0;
                  end
               end else if (grant_if_s) begin
                  state_r      <= WAIT;
                  mem_en       <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_addr     <= if_addr;
                  lat_cnt_r    <= LAT_LOAD;
                  owner_dm_r   <= 1'b0;
                  starve_cnt_r <= '0;
               end
            end
            WAIT: begin
               if (~owner_dm_r & if_cancel) begin
                  cancel_r <= 1'b1;
               end
               if (lat_cnt_r == '0) begin
                  state_r <= RESP;
                  if (owner_dm_r) begin
                     dm_ack <= 1'b1;
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                  end else if (!cancel_now_s) begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt_r <= lat_cnt_r - LW'(1);
               end
            end
            RESP: begin
               state_r  <= IDLE;
               cancel_r <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the memory model returns addr ^ 32'h2002004A
// exactly two cycles after the mem_en cycle.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_cancel;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   int vectors;
   int miscompares;

   logic [31:0] rd1;
   logic [31:0] rd2;
   int          en_cnt;
   logic        prev_en;
   logic        proto_err;
   logic        last_we;
   logic [31:0] last_addr;
   logic [31:0] last_wdata;

   mem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_cancel (if_cancel),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-stage read pipeline: data for the mem_en cycle appears two cycles later.
   always @(posedge clk) begin
      rd1 <= mem_en ? (mem_addr ^ 32'h2002004A) : 32'h0;
      rd2 <= rd1;
   end
   assign mem_rdata = rd2;

   // Port monitor: logs each memory strobe and flags protocol breaches.
   always @(negedge clk) begin
      if (mem_en) begin
         en_cnt     <= en_cnt + 1;
         last_we    <= mem_we;
         last_addr  <= mem_addr;
         last_wdata <= mem_wdata;
      end
      if ((mem_en && prev_en) || (if_ack && dm_ack)) begin
         proto_err <= 1'b1;
      end
      prev_en <= mem_en;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic want_dm, input int limit, output int n);
      logic done;
      done = 1'b0;
      n = 0;
      for (int k = 0; k < limit && !done; k++) begin
         tick();
         n++;
         if (want_dm ? dm_ack : if_ack) done = 1'b1;
      end
      if (!done) n = limit + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      int e0;
      int kind_a[10];
      int at_a[10];
      logic [31:0] rd_a[10];
      int nacks;

      vectors = 0; miscompares = 0;
      en_cnt = 0; prev_en = 1'b0; proto_err = 1'b0;
      last_we = 1'b0; last_addr = 32'h0; last_wdata = 32'h0;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_cancel = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
      repeat (3) tick();
      check_vec("rst_mem_en", {31'h0, mem_en}, 32'h0);
      check_vec("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check_vec("rst_mem_addr", mem_addr, 32'h0);
      check_vec("rst_mem_wdata", mem_wdata, 32'h0);
      check_vec("rst_if_rdata", if_rdata, 32'h0);
      check_vec("rst_dm_rdata", dm_rdata, 32'h0);
      check_vec("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
      check_vec("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      tick();

      // Single fetch of 0x40.
      if_req = 1'b1; if_addr = 32'h40;
      #1 check_vec("f_stall_t0", {31'h0, stall_if}, 32'h1);
      tick();
      check_vec("f_mem_en_t1", {31'h0, mem_en}, 32'h1);
      check_vec("f_mem_addr", mem_addr, 32'h40);
      check_vec("f_mem_we", {31'h0, mem_we}, 32'h0);
      check_vec("f_busy_t1", {31'h0, busy}, 32'h1);
      tick();
      check_vec("f_mem_en_t2", {31'h0, mem_en}, 32'h0);
      tick();
      check_vec("f_stall_t3", {31'h0, stall_if}, 32'h1);
      check_vec("f_ack_t3", {31'h0, if_ack}, 32'h0);
      tick();
      check_vec("f_ack_t4", {31'h0, if_ack}, 32'h1);
      check_vec("f_dm_ack_t4", {31'h0, dm_ack}, 32'h0);
      check_vec("f_rdata", if_rdata, 32'h2002000A);
      check_vec("f_stall_t4", {31'h0, stall_if}, 32'h0);
      if_req = 1'b0;
      tick();
      check_vec("f_ack_t5", {31'h0, if_ack}, 32'h0);
      check_vec("f_busy_t5", {31'h0, busy}, 32'h0);

      // Simultaneous fetch 0x44 and load 0x200: data first.
      if_req = 1'b1; if_addr = 32'h44;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      wait_ack(1'b1, 12, n);
      check_vec("sim_dm_lat", n, 32'd4);
      check_vec("sim_dm_rdata", dm_rdata, 32'h2002024A);
      check_vec("sim_stall_if", {31'h0, stall_if}, 32'h1);
      dm_req = 1'b0;
      tick();
      check_vec("sim_en_t5", {31'h0, mem_en}, 32'h0);
      check_vec("sim_stall_t5", {31'h0, stall_if}, 32'h1);
      tick();
      check_vec("sim_en_t6", {31'h0, mem_en}, 32'h1);
      check_vec("sim_addr_t6", mem_addr, 32'h44);
      wait_ack(1'b0, 12, n);
      check_vec("sim_if_lat", n, 32'd3);
      check_vec("sim_if_rdata", if_rdata, 32'h2002000E);
      if_req = 1'b0;
      tick();

      // Store 0xDEADBEEF to 0x100; load data must stay.
      e0 = en_cnt;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
      wait_ack(1'b1, 12, n);
      check_vec("st_lat", n, 32'd4);
      check_vec("st_en_count", en_cnt - e0, 32'd1);
      check_vec("st_we", {31'h0, last_we}, 32'h1);
      check_vec("st_addr", last_addr, 32'h100);
      check_vec("st_wdata", last_wdata, 32'hDEADBEEF);
      check_vec("st_dm_rdata", dm_rdata, 32'h2002024A);
      dm_req = 1'b0; dm_we = 1'b0;
      tick();

      // Starvation: data held continuously, fetch 0x48 pending.
      for (int i = 0; i < 10; i++) begin
         kind_a[i] = 0; at_a[i] = 0; rd_a[i] = 32'h0;
      end
      nacks = 0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
      if_req = 1'b1; if_addr = 32'h48;
      for (int c = 1; c <= 80 && nacks < 10; c++) begin
         tick();
         if (dm_ack || if_ack) begin
            kind_a[nacks] = dm_ack ? 1 : 2;
            at_a[nacks]   = c;
            rd_a[nacks]   = if_ack ? if_rdata : dm_rdata;
            nacks++;
         end
      end
      dm_req = 1'b0; if_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_vec($sformatf("stv_kind%0d", i), kind_a[i], (i % 5 == 4) ? 32'd2 : 32'd1);
         check_vec($sformatf("stv_cyc%0d", i), at_a[i], 4 + 5 * i);
         if (i % 5 == 4) check_vec($sformatf("stv_rdata%0d", i), rd_a[i], 32'h20020002);
      end
      tick();
      check_vec("stv_idle", {31'h0, busy}, 32'h0);

      // Cancel during the second WAIT cycle of fetch 0x4C; a load to 0x300 waits.
      if_req = 1'b1; if_addr = 32'h4C;
      tick();
      check_vec("cx_en_t1", {31'h0, mem_en}, 32'h1);
      check_vec("cx_addr_t1", mem_addr, 32'h4C);
      tick();
      if_cancel = 1'b1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      #1 check_vec("cx_stall_if", {31'h0, stall_if}, 32'h0);
      tick();
      if_cancel = 1'b0; if_req = 1'b0;
      tick();
      check_vec("cx_no_ack", {31'h0, if_ack}, 32'h0);
      check_vec("cx_rdata_kept", if_rdata, 32'h20020002);
      check_vec("cx_busy_t4", {31'h0, busy}, 32'h1);
      tick();
      check_vec("cx_busy_t5", {31'h0, busy}, 32'h0);
      check_vec("cx_en_t5", {31'h0, mem_en}, 32'h0);
      tick();
      check_vec("cx_dm_en_t6", {31'h0, mem_en}, 32'h1);
      check_vec("cx_dm_addr", mem_addr, 32'h300);
      wait_ack(1'b1, 12, n);
      check_vec("cx_dm_lat", n, 32'd3);
      check_vec("cx_dm_rdata", dm_rdata, 32'h2002034A);
      dm_req = 1'b0;
      tick();

      // Reset in the first WAIT cycle of fetch 0x50.
      if_req = 1'b1; if_addr = 32'h50;
      tick();
      rst = 1'b1;
      #1;
      check_vec("rw_mem_en", {31'h0, mem_en}, 32'h0);
      check_vec("rw_mem_addr", mem_addr, 32'h0);
      check_vec("rw_busy", {31'h0, busy}, 32'h0);
      check_vec("rw_if_rdata", if_rdata, 32'h0);
      if_req = 1'b0;
      tick();
      rst = 1'b0;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (if_ack || dm_ack) n++;
      end
      check_vec("rw_no_ack", n, 32'd0);
      if_req = 1'b1; if_addr = 32'h54;
      wait_ack(1'b0, 12, n);
      check_vec("rw_next_lat", n, 32'd4);
      check_vec("rw_next_rdata", if_rdata, 32'h2002001E);
      if_req = 1'b0;
      tick();
      tick();

      check_vec("protocol", {31'h0, proto_err}, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store.
- Sits between the IF/MEM stage logic and the memory macro, and sequences each access through a fixed-latency handshake.
- Generates the fetch and data stall signals that freeze the pipeline while an access is pending.
- Data accesses have priority; a starvation guard and a fetch-cancel input (branch flush) are included.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range >=1.
- STARVE_MAX, 4, consecutive data grants with a fetch pending before the fetch is forced to win; legal range >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack or if_cancel.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_cancel  in  1  flush of the outstanding or requested fetch.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  if_req & ~if_ack & ~if_cancel (combinational).
- stall_mem  out  1  dm_req & ~dm_ack (combinational).
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: every registered output is 0 (mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ack, dm_ack); state=IDLE; latency counter=0; starvation counter=0; cancel flag=0.
- Reset mid-access: the access is abandoned, no ack is issued, and mem_en drops immediately.
- States: IDLE, WAIT, RESP.
- IDLE, arbitration on the sampled requests; priority order:
  - if dm_req, and not (if_req & ~if_cancel & starve_cnt==STARVE_MAX): grant data;
  - else if if_req & ~if_cancel: grant fetch;
  - else stay in IDLE.
- On a grant: go to WAIT; register mem_en=1, mem_addr, mem_we (dm_we for data, 0 for fetch), mem_wdata (for a store); load the latency counter with MEM_LATENCY; record the granted owner.
- WAIT: mem_en=1 in the first WAIT cycle only, 0 afterwards; mem_addr, mem_we and mem_wdata hold until RESP.
  - WAIT lasts MEM_LATENCY+1 cycles; the counter decrements each cycle.
  - At the end of the cycle where the counter is 0, mem_rdata is captured into the owner's rdata register (loads and fetches only; stores leave rdata unchanged), then the state goes to RESP.
- RESP: exactly one cycle.
  - The owner's ack is 1; the other ack is 0.
  - Requests are ignored in this cycle (requesters deassert req after the ack edge); next state is IDLE.
- Latency: request seen in IDLE at cycle T0 gives mem_en at T1 and ack at T0+MEM_LATENCY+2; with the defaults, ack at T0+4.
- Throughput: one access per MEM_LATENCY+3 cycles.
- Starvation counter:
  - increments (saturating at STARVE_MAX) on a data grant while if_req & ~if_cancel;
  - clears on any fetch grant;
  - clears on a data grant with no fetch pending.
- Fetch cancel:
  - if_cancel=1 during a fetch-owned WAIT sets the cancel flag. The memory access still completes (the port is not aborted), but RESP then produces if_ack=0 and if_rdata keeps its old value. The flag clears in RESP.
  - if_cancel=1 in IDLE suppresses the fetch grant that cycle.
  - if_cancel has no effect on data accesses.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_MAX: data wins and the fetch waits; stall_if stays 1 throughout.
- if_ack and dm_ack are never 1 in the same cycle.
- mem_en is never 1 in two consecutive cycles.

Test Plan:
- Single fetch: if_addr=0x40, mem returns 0x2002000A two cycles after mem_en → mem_en at T1 with mem_addr=0x40, mem_we=0; if_ack at T4 with if_rdata=0x2002000A; stall_if=1 during T0..T3.
- Store: dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → one mem_en cycle with mem_we=1 and those addr/data; dm_ack at T4; dm_rdata unchanged.
- Simultaneous requests (fetch 0x44, load 0x200) → data granted first, dm_ack at T4; fetch mem_en at T6; if_ack at T9.
- Starvation: dm_req held continuously (new request each cycle after ack) with if_req pending and STARVE_MAX=4 → 4 data acks, then a fetch grant, then the counter restarts from 0.
- Cancel: if_cancel pulsed in the second WAIT cycle of a fetch → mem access still issued, no if_ack, if_rdata unchanged, busy returns to 0 on schedule; a pending dm_req is granted in the following IDLE.
- Reset mid-WAIT: rst asserted in a WAIT cycle → all outputs 0 immediately; no ack after release; the next request completes with the normal latency.
